// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table sweeper and its benches.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } sweep_state_e;

  // Default geometry; the top derives its own row count from N_IN.
  localparam int unsigned N_IN_DEFAULT = 3;
  localparam int unsigned ROWS         = 2**N_IN_DEFAULT;

  // Width of the settle counter; covers SETTLE values 0..15.
  localparam int unsigned SETTLE_W = 4;

  // Golden table of the three-input reference SOP: minterms 0, 4, 5, 7.
  localparam logic [7:0] MT_SOP3 = 8'hB1;

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Loadable down-counter that holds each stimulus for SETTLE extra cycles.
module settle_counter
  import truth_table_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  logic [SETTLE_W-1:0] count_q;
  logic [SETTLE_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = SETTLE_W'(SETTLE);
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A load of zero expires at once, so DRIVE lasts a single cycle.
  assign expired_o = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every minterm of an N_IN-input function, captures two outputs into
// truth tables and reports whether and where the tables first differ.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 f_a,
  input  logic                 f_b,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_a,
  output logic [2**N_IN-1:0]   table_b,
  output logic                 mismatch,
  output logic [N_IN-1:0]      first_bad,
  input  logic [N_IN-1:0]      rd_idx,
  output logic                 rd_a,
  output logic                 rd_b
);

  localparam int unsigned     NROWS = 2**N_IN;
  localparam logic [N_IN-1:0] LAST  = N_IN'(NROWS - 1);

  sweep_state_e     state_q;
  logic [N_IN-1:0]  stim_q;
  logic             busy_q;
  logic             done_q;
  logic [NROWS-1:0] table_a_q;
  logic [NROWS-1:0] table_b_q;
  logic             mismatch_q;
  logic [N_IN-1:0]  first_bad_q;

  logic             settle_load;
  logic             settle_en;
  logic             settle_expired;

  // Reload on sweep entry and on every SAMPLE, which always returns to DRIVE
  // or finishes the sweep.
  assign settle_load = ((state_q == IDLE) && start) || (state_q == SAMPLE);
  assign settle_en   = (state_q == DRIVE);

  settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (settle_load),
    .en_i      (settle_en),
    .expired_o (settle_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stim_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      table_a_q   <= '0;
      table_b_q   <= '0;
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= DRIVE;
            stim_q      <= '0;
            busy_q      <= 1'b1;
            table_a_q   <= '0;
            table_b_q   <= '0;
            mismatch_q  <= 1'b0;
            first_bad_q <= '0;
          end
        end
        DRIVE: begin
          if (settle_expired) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          table_a_q[stim_q] <= f_a;
          table_b_q[stim_q] <= f_b;
          // Ascending sweep: the first difference seen is the lowest index.
          if ((f_a != f_b) && !mismatch_q) begin
            mismatch_q  <= 1'b1;
            first_bad_q <= stim_q;
          end
          if (stim_q == LAST) begin
            state_q <= DONE;
          end else begin
            stim_q  <= stim_q + 1'b1;
            state_q <= DRIVE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_a   = table_a_q;
  assign table_b   = table_b_q;
  assign mismatch  = mismatch_q;
  assign first_bad = first_bad_q;
  assign rd_a      = table_a_q[rd_idx];
  assign rd_b      = table_b_q[rd_idx];

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: expected sweep results are queued at start, compared at done.
module tb_truth_table_sweeper;
  import truth_table_pkg::*;

  localparam int S3 = 1;
  localparam int S2 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Three-input instance
  logic       start3, f_a3, f_b3, busy3, done3, mismatch3, rd_a3, rd_b3;
  logic [2:0] stim3, first_bad3, rd_idx3;
  logic [7:0] table_a3, table_b3;
  int         mode3;

  // Two-input instance, SETTLE=0
  logic       start2, f_a2, f_b2, busy2, done2, mismatch2, rd_a2, rd_b2;
  logic [1:0] stim2, first_bad2, rd_idx2;
  logic [3:0] table_a2, table_b2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] ta;
    logic [7:0] tb;
    logic       mm;
    logic [2:0] fb;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  function automatic logic sop3(input logic [2:0] s);
    logic a, b, c;
    a = s[2]; b = s[1]; c = s[0];
    return (~a & ~b & ~c) | (a & ~b & ~c) | (a & ~b & c) | (a & b & c);
  endfunction

  function automatic logic fb3(input int m, input logic [2:0] s);
    logic a, b, c;
    a = s[2]; b = s[1]; c = s[0];
    if (m == 0) return (a & c) | (~b & ~c);
    else if (m == 1) return 1'b0;
    else return a & c;
  endfunction

  assign f_a3 = sop3(stim3);
  assign f_b3 = fb3(mode3, stim3);
  assign f_a2 = stim2[1] ^ stim2[0];
  assign f_b2 = stim2[1] ^ stim2[0];

  truth_table_sweeper #(.N_IN(3), .SETTLE(S3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .f_a(f_a3), .f_b(f_b3),
    .stim(stim3), .busy(busy3), .done(done3), .table_a(table_a3),
    .table_b(table_b3), .mismatch(mismatch3), .first_bad(first_bad3),
    .rd_idx(rd_idx3), .rd_a(rd_a3), .rd_b(rd_b3)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(S2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .f_a(f_a2), .f_b(f_b2),
    .stim(stim2), .busy(busy2), .done(done2), .table_a(table_a2),
    .table_b(table_b2), .mismatch(mismatch2), .first_bad(first_bad2),
    .rd_idx(rd_idx2), .rd_a(rd_a2), .rd_b(rd_b2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push3(input string name, input int m);
    exp_t e;
    e.name = name; e.ta = '0; e.tb = '0; e.mm = 1'b0; e.fb = '0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] s;
      s = 3'(i);
      e.ta[i] = sop3(s);
      e.tb[i] = fb3(m, s);
      if (e.ta[i] != e.tb[i] && !e.mm) begin
        e.mm = 1'b1;
        e.fb = s;
      end
    end
    e.cyc = 8 * (S3 + 2) + 1;
    sb.push_back(e);
  endtask

  task automatic push2(input string name);
    exp_t e;
    e.name = name; e.ta = '0; e.tb = '0; e.mm = 1'b0; e.fb = '0;
    for (int i = 0; i < 4; i++) begin
      e.ta[i] = (i == 1) || (i == 2);
      e.tb[i] = e.ta[i];
    end
    e.cyc = 4 * (S2 + 2) + 1;
    sb.push_back(e);
  endtask

  // Pulse start for one cycle; returns #1 after the accepting edge.
  task automatic kick(input int which);
    @(negedge clk);
    if (which == 3) start3 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    if (which == 3) start3 = 1'b0; else start2 = 1'b0;
    check("busy_rise", (which == 3) ? busy3 : busy2, 1'b1);
  endtask

  // Count edges after the accepting edge until done; optional stray start pulse.
  task automatic wait_done(input int which, input int repulse_at, output int n);
    logic d;
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      #1;
      if (which == 3 && repulse_at > 0) start3 = (n == repulse_at);
      d = (which == 3) ? done3 : done2;
      if (d) break;
      if (n >= 300) begin
        check("done_timeout", 32'(n), 32'd0);
        n = -1;
        break;
      end
    end
  endtask

  task automatic compare_result(input int which, input int n);
    exp_t e;
    logic [7:0] ta, tb;
    logic [2:0] fb;
    logic mm, bz;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (which == 3) begin
      ta = table_a3; tb = table_b3; mm = mismatch3; fb = first_bad3; bz = busy3;
    end else begin
      ta = {4'h0, table_a2}; tb = {4'h0, table_b2}; mm = mismatch2;
      fb = {1'b0, first_bad2}; bz = busy2;
    end
    $display("sweep %s: cycles=%0d table_a=%h table_b=%h mismatch=%0d first_bad=%0d",
             e.name, n, ta, tb, mm, fb);
    check({e.name, "_cycles"}, 32'(n), 32'(e.cyc));
    check({e.name, "_table_a"}, 32'(ta), 32'(e.ta));
    check({e.name, "_table_b"}, 32'(tb), 32'(e.tb));
    check({e.name, "_mismatch"}, 32'(mm), 32'(e.mm));
    check({e.name, "_first_bad"}, 32'(fb), 32'(e.fb));
    check({e.name, "_busy_fall"}, 32'(bz), 32'd0);
  endtask

  task automatic check_reset3(input string tag);
    check({tag, "_stim"}, 32'(stim3), 32'd0);
    check({tag, "_busy"}, 32'(busy3), 32'd0);
    check({tag, "_done"}, 32'(done3), 32'd0);
    check({tag, "_table_a"}, 32'(table_a3), 32'd0);
    check({tag, "_table_b"}, 32'(table_b3), 32'd0);
    check({tag, "_mismatch"}, 32'(mismatch3), 32'd0);
    check({tag, "_first_bad"}, 32'(first_bad3), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start3 = 1'b0; start2 = 1'b0; mode3 = 0;
    rd_idx3 = '0; rd_idx2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset3("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Equivalent SOP and minimized form
    mode3 = 0;
    push3("equiv", 0);
    kick(3);
    wait_done(3, 0, n);
    compare_result(3, n);
    check("equiv_golden", 32'(table_a3), 32'(MT_SOP3));
    @(posedge clk); #1;
    check("equiv_done_pulse", 32'(done3), 32'd0);

    // f_b tied low
    mode3 = 1;
    push3("fb_zero", 1);
    kick(3);
    wait_done(3, 0, n);
    compare_result(3, n);

    // f_b = ac, then random-access reads
    mode3 = 2;
    push3("fb_ac", 2);
    kick(3);
    wait_done(3, 0, n);
    compare_result(3, n);
    rd_idx3 = 3'd4; #1;
    check("rd4_a", 32'(rd_a3), 32'd1);
    check("rd4_b", 32'(rd_b3), 32'd0);
    rd_idx3 = 3'd5; #1;
    check("rd5_a", 32'(rd_a3), 32'd1);
    check("rd5_b", 32'(rd_b3), 32'd1);

    // Stray start mid-sweep must be ignored
    mode3 = 0;
    push3("repulse", 0);
    kick(3);
    wait_done(3, 10, n);
    compare_result(3, n);

    // Reset in the middle of a sweep
    kick(3);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset3("abort");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done3), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset3("abort_release");

    // Two-input XOR, SETTLE=0
    push2("xor2");
    kick(2);
    wait_done(2, 0, n);
    compare_result(2, n);
    rd_idx2 = 2'd2; #1;
    check("xor2_rd2_a", 32'(rd_a2), 32'd1);
    check("xor2_rd2_b", 32'(rd_b2), 32'd1);

    // Start held high: restart follows one IDLE cycle
    push2("held1");
    push2("held2");
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    check("held_busy_rise", 32'(busy2), 32'd1);
    wait_done(2, 0, n);
    compare_result(2, n);
    @(posedge clk); #1;
    start2 = 1'b0;
    check("held_restart_busy", 32'(busy2), 32'd1);
    check("held_restart_done", 32'(done2), 32'd0);
    wait_done(2, 0, n);
    compare_result(2, n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
